execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Ports SHALL be exactly, in order:
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 RegWriteE, MemWriteE, MemToRegE  in  1 each  control from the ID/EX register.
REQ-005 alufuncE  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 MUL.
REQ-006 srcDataE1, srcDataE2  in  16 each  operand A, B from the ID/EX register.
REQ-007 srcAddE1, srcAddE2  in  4 each  source register numbers of A, B.
REQ-008 destAddE  in  4  destination register.
REQ-009 RegWriteW  in  1, destAddW  in  4, resultW  in  16  write-back forwarding source.
REQ-010 stallE  out  1  high: ID/EX and all upstream stages hold.
REQ-011 RegWriteM, MemWriteM, MemToRegM  out  1 each  registered control to MEM.
REQ-012 aluResultM  out  16, writeDataM  out  16, destAddM  out  4  registered EX/MEM data.
REQ-013 zeroM, carryM  out  1 each  registered flags.

Function
REQ-014 Forwarded A SHALL be aluResultM if RegWriteM and destAddM==srcAddE1; else resultW if RegWriteW and destAddW==srcAddE1; else srcDataE1; B likewise with srcAddE2/srcDataE2; M has priority over W.
REQ-015 Forwarding SHALL apply to all 16 register numbers (R0 not special); load-use hazards are excluded (decode hazard unit's job).
REQ-016 ADD/SUB/AND SHALL be single-cycle: result registered into EX/MEM at the edge ending the cycle they are presented; stallE=0.
REQ-017 ADD result = (A+B) mod 2^16, carryM = bit 16 of the sum.
REQ-018 SUB result = (A-B) mod 2^16, carryM = 1 iff A<B unsigned (borrow).
REQ-019 AND result = A&B, carryM=0.
REQ-020 MUL result = low 16 bits of unsigned A*B; carryM = OR of product bits 31:16.
REQ-021 zeroM SHALL be 1 iff the registered result equals 0x0000.
REQ-022 writeDataM SHALL be forwarded B; destAddM = destAddE; control outputs copy their E inputs.
REQ-023 MUL FSM states: IDLE, BUSY, DONE.
REQ-024 IDLE with alufuncE=11: capture forwarded A, B; clear product and 4-bit counter; stallE=1 combinationally in that cycle; next BUSY.
REQ-025 BUSY: one shift-add iteration per cycle, stallE=1; after iteration 16 (counter==15) next DONE.
REQ-026 DONE: stallE=0; EX/MEM loads the MUL result and control; next IDLE.
REQ-027 A MUL SHALL hold stallE high for exactly 17 consecutive cycles and reach EX/MEM at the edge ending cycle 18 after presentation.
REQ-028 While stallE=1, EX/MEM SHALL load a bubble: all control outputs 0, data/flags 0, destAddM 0.
REQ-029 Operands SHALL NOT be re-sampled during BUSY/DONE; forwarding values changing mid-MUL have no effect.
REQ-030 Back-to-back MULs: DONE returns to IDLE, next MUL starts cleanly, stallE drops for exactly the DONE cycle.

Reset
REQ-031 reset low SHALL immediately force FSM to IDLE, counter/product to 0, all EX/MEM outputs to 0, stallE to 0 (alufuncE permitting), independent of clk.
REQ-032 Reset mid-MUL SHALL abandon the operation; no partial result ever appears on aluResultM.
REQ-033 After reset release, first rising edge SHALL operate normally.

Structure
REQ-034 Shared package cpu_pkg SHALL hold DATA_W=16, REG_ADDR_W=4, alufunc encodings, MUL_ITER=16 and the MUL FSM state type.
REQ-035 The iterative multiplier SHALL be a sub-module mul16_iter (start, operands, busy/done, 32-bit product); forwarding, single-cycle ALU and EX/MEM register remain in execute_stage.

Verification
REQ-036 ADD A=0xFFFF, B=0x0001 -> next edge aluResultM=0x0000, zeroM=1, carryM=1, stallE never high.
REQ-037 SUB A=0x0003, B=0x0005 -> aluResultM=0xFFFE, carryM=1, zeroM=0.
REQ-038 Forwarding: RegWriteM=1, destAddM=3, aluResultM=0x0010; RegWriteW=1, destAddW=3, resultW=0x0020; srcAddE1=3, srcDataE1=0x9999, ADD B=1 -> aluResultM=0x0011.
REQ-039 MUL A=0x0100, B=0x0100 -> stallE high 17 cycles, 17 bubbles on EX/MEM, then aluResultM=0x0000, carryM=1, zeroM=1.
REQ-040 MUL A=0x00FF, B=0x0003 with reset low at BUSY cycle 5 -> all outputs 0 at once, stallE=0, FSM IDLE; after release an ADD 2+2 gives 0x0004.
REQ-041 Two back-to-back MULs (3*5, 7*9) -> results 0x000F then 0x003F, stallE low for exactly one cycle between them.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared widths, ALU function encodings, multiplier FSM state
//             type and the operand-forwarding helper for the execute stage.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int MUL_ITER   = 16;
  localparam int CNT_W      = $clog2(MUL_ITER);

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MUL = 2'b11
  } aluFunc_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mulState_t;

  // The younger producer (EX/MEM) wins over write-back; R0 is an ordinary
  // register here, so no zero-register exclusion.
  function automatic logic [DATA_W-1:0] forwardOperand(
    input logic [REG_ADDR_W-1:0] srcAdd,
    input logic [DATA_W-1:0]     srcData,
    input logic                  regWriteM,
    input logic [REG_ADDR_W-1:0] destAddM,
    input logic [DATA_W-1:0]     aluResultM,
    input logic                  regWriteW,
    input logic [REG_ADDR_W-1:0] destAddW,
    input logic [DATA_W-1:0]     resultW
  );
    if (regWriteM && (destAddM == srcAdd))
      return aluResultM;
    else if (regWriteW && (destAddW == srcAdd))
      return resultW;
    else
      return srcData;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul16_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mul16_iter
//  Purpose  : Iterative 16x16 unsigned shift-add multiplier, one partial
//             product per clock.  IDLE captures operands on start, BUSY runs
//             MUL_ITER iterations, DONE presents the product for one cycle.
//  Ports    : clk, reset (async, active-low), start, opA, opB,
//             idle/busy/done status, product (2*DATA_W bits, valid in DONE)
//  Revision : 1.0 - initial release
// ============================================================================
module mul16_iter
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     opA,
  input  logic [DATA_W-1:0]     opB,
  output logic                  idle,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  mulState_t               r_state;
  mulState_t               w_stateNext;
  logic [CNT_W-1:0]        r_count;
  logic [2*DATA_W-1:0]     r_mcand;
  logic [DATA_W-1:0]       r_mplier;
  logic [2*DATA_W-1:0]     r_product;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MUL_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      MUL_IDLE: if (start) w_stateNext = MUL_BUSY;
      MUL_BUSY: if (r_count == CNT_W'(MUL_ITER - 1)) w_stateNext = MUL_DONE;
      MUL_DONE: w_stateNext = MUL_IDLE;
      default:  w_stateNext = MUL_IDLE;
    endcase
  end

  // Operands are only sampled in IDLE; later changes on opA/opB are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
    end else if ((r_state == MUL_IDLE) && start) begin
      r_count   <= '0;
      r_mcand   <= {{DATA_W{1'b0}}, opA};
      r_mplier  <= opB;
      r_product <= '0;
    end else if (r_state == MUL_BUSY) begin
      if (r_mplier[0]) r_product <= r_product + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign idle    = (r_state == MUL_IDLE);
  assign busy    = (r_state == MUL_BUSY);
  assign done    = (r_state == MUL_DONE);
  assign product = r_product;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : execute_stage
//  Purpose  : Pipeline EX stage: operand forwarding from MEM/WB, single-cycle
//             ADD/SUB/AND, iterative MUL with pipeline stall, EX/MEM register.
//  Ports    : clk, reset (async, active-low)
//             ID/EX in : RegWriteE, MemWriteE, MemToRegE, alufuncE,
//                        srcDataE1/2, srcAddE1/2, destAddE
//             WB fwd in: RegWriteW, destAddW, resultW
//             out      : stallE (combinational), EX/MEM registered control,
//                        aluResultM, writeDataM, destAddM, zeroM, carryM
//  Revision : 1.0 - initial release
// ============================================================================
module execute_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  MemToRegE,
  input  logic [1:0]            alufuncE,
  input  logic [DATA_W-1:0]     srcDataE1,
  input  logic [DATA_W-1:0]     srcDataE2,
  input  logic [REG_ADDR_W-1:0] srcAddE1,
  input  logic [REG_ADDR_W-1:0] srcAddE2,
  input  logic [REG_ADDR_W-1:0] destAddE,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] destAddW,
  input  logic [DATA_W-1:0]     resultW,
  output logic                  stallE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  MemToRegM,
  output logic [DATA_W-1:0]     aluResultM,
  output logic [DATA_W-1:0]     writeDataM,
  output logic [REG_ADDR_W-1:0] destAddM,
  output logic                  zeroM,
  output logic                  carryM
);

  logic [DATA_W-1:0]     w_fwdA;
  logic [DATA_W-1:0]     w_fwdB;
  logic                  w_isMul;
  logic                  w_mulIdle;
  logic                  w_mulBusy;
  logic                  w_mulDone;
  logic [2*DATA_W-1:0]   w_mulProduct;
  logic [DATA_W-1:0]     w_aluRes;
  logic                  w_aluCarry;
  logic [DATA_W-1:0]     w_exRes;
  logic                  w_exCarry;
  logic [DATA_W-1:0]     w_exWriteData;
  logic [DATA_W-1:0]     r_mulB;

  logic                  r_regWriteM;
  logic                  r_memWriteM;
  logic                  r_memToRegM;
  logic [DATA_W-1:0]     r_aluResultM;
  logic [DATA_W-1:0]     r_writeDataM;
  logic [REG_ADDR_W-1:0] r_destAddM;
  logic                  r_zeroM;
  logic                  r_carryM;

  assign w_fwdA = forwardOperand(srcAddE1, srcDataE1, r_regWriteM, r_destAddM,
                                 r_aluResultM, RegWriteW, destAddW, resultW);
  assign w_fwdB = forwardOperand(srcAddE2, srcDataE2, r_regWriteM, r_destAddM,
                                 r_aluResultM, RegWriteW, destAddW, resultW);

  assign w_isMul = (alufuncE == ALU_MUL);

  mul16_iter uMul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_isMul),
    .opA     (w_fwdA),
    .opB     (w_fwdB),
    .idle    (w_mulIdle),
    .busy    (w_mulBusy),
    .done    (w_mulDone),
    .product (w_mulProduct)
  );

  // Stall starts combinationally in the presentation cycle and covers BUSY;
  // the DONE cycle is the only MUL cycle that lets the pipeline advance.
  assign stallE = w_mulBusy | (w_mulIdle & w_isMul);

  // Forwarded B at MUL start is kept so the store data of the MUL is immune
  // to forwarding changes during the stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_mulB <= '0;
    else if (w_mulIdle && w_isMul) r_mulB <= w_fwdB;
  end

  always_comb begin
    w_aluRes   = '0;
    w_aluCarry = 1'b0;
    case (alufuncE)
      ALU_ADD: {w_aluCarry, w_aluRes} = {1'b0, w_fwdA} + {1'b0, w_fwdB};
      ALU_SUB: begin
        w_aluRes   = w_fwdA - w_fwdB;
        w_aluCarry = (w_fwdA < w_fwdB);
      end
      ALU_AND: w_aluRes = w_fwdA & w_fwdB;
      default: ;
    endcase
  end

  always_comb begin
    w_exRes       = w_aluRes;
    w_exCarry     = w_aluCarry;
    w_exWriteData = w_fwdB;
    if (w_mulDone) begin
      w_exRes       = w_mulProduct[DATA_W-1:0];
      w_exCarry     = |w_mulProduct[2*DATA_W-1:DATA_W];
      w_exWriteData = r_mulB;
    end
  end

  // EX/MEM register; a stall inserts a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || stallE) begin
      r_regWriteM  <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_memToRegM  <= 1'b0;
      r_aluResultM <= '0;
      r_writeDataM <= '0;
      r_destAddM   <= '0;
      r_zeroM      <= 1'b0;
      r_carryM     <= 1'b0;
    end else begin
      r_regWriteM  <= RegWriteE;
      r_memWriteM  <= MemWriteE;
      r_memToRegM  <= MemToRegE;
      r_aluResultM <= w_exRes;
      r_writeDataM <= w_exWriteData;
      r_destAddM   <= destAddE;
      r_zeroM      <= (w_exRes == '0);
      r_carryM     <= w_exCarry;
    end
  end

  assign RegWriteM  = r_regWriteM;
  assign MemWriteM  = r_memWriteM;
  assign MemToRegM  = r_memToRegM;
  assign aluResultM = r_aluResultM;
  assign writeDataM = r_writeDataM;
  assign destAddM   = r_destAddM;
  assign zeroM      = r_zeroM;
  assign carryM     = r_carryM;

endmodule
`default_nettype wire
